flit_splitter: RTL and testbench
================================

Name: flit_splitter

Overview:
Clocked one-to-three flit demultiplexer: the output-side counterpart of the three-to-one arbiter merge in the NoC router. Accepts flits on a single valid/ready input channel and steers each flit to one of three output channels by the destination field in the flit's top two bits. Each output has its own FIFO, so a stalled output blocks only flits addressed to it. Flits with an invalid destination are dropped and counted.

Parameters:
WIDTH, 8, flit width in bits (>= 3); bits [WIDTH-1:WIDTH-2] are the destination field.
DEPTH, 2, entries per output FIFO (power of two, >= 2).
CNT_W, 8, width of the saturating drop counter.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
in_data  input  WIDTH  incoming flit.
in_valid  input  1  in_data is valid.
in_ready  output  1  splitter accepts in_data this cycle.
out_data[0..2]  output  3 x WIDTH  head flit of each output FIFO (three separate ports: out0_data, out1_data, out2_data).
out_valid[0..2]  output  1 each  FIFO non-empty (out0_valid, out1_valid, out2_valid).
out_ready[0..2]  input  1 each  downstream consumes the head (out0_ready, out1_ready, out2_ready).
drop_count  output  CNT_W  number of flits dropped for an invalid destination.

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low, on rst_n.
- Reset values:
  - All FIFOs empty; out*_valid = 0.
  - out*_data = 0.
  - drop_count = 0.
  - in_ready follows its combinational definition (below) with empty FIFOs.
- Destination decode, d = in_data[WIDTH-1:WIDTH-2]:
  - 2'b00 -> port 0; 2'b01 -> port 1; 2'b10 -> port 2.
  - 2'b11 -> invalid.
- in_ready (combinational):
  - Valid d: in_ready = !full[d].
  - d = 11: in_ready = 1.
  - in_ready must not depend on any out*_ready (no combinational feedthrough).
- Transfer rule: a flit transfers when in_valid && in_ready at the rising edge.
  - Valid d: push the full flit unchanged into FIFO d.
  - d = 11: discard the flit; drop_count increments, saturating at 2^CNT_W - 1.
- Output handshake: pop FIFO k when outk_valid && outk_ready. Pops on different ports are independent and may coincide with a push.
- Latency: a flit accepted in cycle N into an empty FIFO appears as outk_valid=1 in cycle N+1.
- FIFO order: flits addressed to one port leave strictly in arrival order. There is no ordering guarantee across ports.
- Full FIFO: in_ready = 0 for that destination even if a pop occurs in the same cycle; the push happens in the next cycle. A blocked flit stalls the input, so later flits for other ports also wait (no reordering at the input).
- Empty FIFO: outk_valid = 0 and outk_data holds its last value, or 0 if nothing has been pushed since reset.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and pointers advance modulo DEPTH.
- Pointers: log2(DEPTH)+1 bits with an extra wrap bit. full = (MSBs differ, LSBs equal); empty = pointers equal.
- in_valid protocol: once asserted, in_valid and in_data hold until the transfer. The bench checks this and the RTL does not.
- Reset mid-operation: every FIFO flushes immediately. Flits in flight are lost, and drop_count does not count them.

Decomposition:
- Package noc_pkg:
  - typedef enum logic [1:0] dest_t {DEST_P0=2'b00, DEST_P1=2'b01, DEST_P2=2'b10, DEST_INV=2'b11}.
  - Constants NUM_OUT = 3 and DEST_MSB_OFS = 2.
- Sub-module sync_fifo #(WIDTH, DEPTH) with push, pop, din, dout, full, empty; instantiated three times.
- Top level: decode, in_ready mux, push demux and the drop counter.

Test Plan:
1. Reset with rst_n=0 for 3 cycles, then release -> out0..2_valid=0, drop_count=0, in_ready=1.
2. All out_ready=1; send 0x05, 0x45, 0x85 back-to-back -> out0_data=0x05, out1_data=0x45, out2_data=0x85, each valid exactly one cycle after its acceptance.
3. out0_ready=0; send 0x01, 0x02, 0x03 -> first two accepted, in_ready=0 while 0x03 is presented. Raise out0_ready -> 0x01, 0x02, 0x03 emerge in order and 0x03 is pushed one cycle after the first pop.
4. Send 0xC0 five times with CNT_W=2 -> in_ready=1 throughout, no outk_valid, drop_count saturates at 3.
5. Port 1 full and port 2 empty, present 0x41 then 0x81 -> 0x81 is not accepted until 0x41 is accepted (head-of-line order preserved).
6. Assert rst_n=0 asynchronously mid-cycle with all FIFOs holding data -> all outk_valid drop to 0 before the next clock edge and stay 0 after release.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: destination encoding and shared constants for the NoC splitter.
package noc_pkg;

    typedef enum logic [1:0] {
        DEST_P0  = 2'b00,
        DEST_P1  = 2'b01,
        DEST_P2  = 2'b10,
        DEST_INV = 2'b11
    } dest_t;

    localparam int NUM_OUT      = 3;
    localparam int DEST_MSB_OFS = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers.
// Ports: clk, rst_n (async, active low); push/din write side; pop/dout read side;
// full/empty status. dout shows the head when non-empty, else the last flit popped (0 after reset).
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] last;
    logic             do_push, do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Storage is stale once popped, so the empty-time output comes from a held copy.
    assign dout    = empty ? last : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                last   <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/flit_splitter.sv
// flit_splitter: steers input flits to one of three output FIFOs by destination field.
// Ports: clk, rst_n (async, active low); in_data/in_valid/in_ready input channel;
// outK_data/outK_valid/outK_ready per output (K=0..2); drop_count counts invalid-destination flits.
module flit_splitter
    import noc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [CNT_W-1:0] drop_count
);
    dest_t              d;
    logic [NUM_OUT-1:0] full, empty, push, pop;
    logic [NUM_OUT:0]   full_x;
    logic [WIDTH-1:0]   dout [NUM_OUT];

    assign d        = dest_t'(in_data[WIDTH-1 -: DEST_MSB_OFS]);
    // The invalid destination maps to a never-full slot, so drops are always accepted.
    assign full_x   = {1'b0, full};
    assign in_ready = !full_x[d];
    assign pop      = {out2_ready, out1_ready, out0_ready};

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_port
        assign push[k] = in_valid && in_ready && (d == dest_t'(2'(k)));
        sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data),
            .dout  (dout[k]),
            .full  (full[k]),
            .empty (empty[k])
        );
    end

    assign out0_data  = dout[0];
    assign out1_data  = dout[1];
    assign out2_data  = dout[2];
    assign out0_valid = !empty[0];
    assign out1_valid = !empty[1];
    assign out2_valid = !empty[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_count <= '0;
        else if (in_valid && d == DEST_INV && drop_count != '1)
            drop_count <= drop_count + 1'b1;
    end

endmodule

// File: tb/tb_flit_splitter.sv
// tb_flit_splitter: directed stimulus with a queue-based reference model checked every cycle.
module tb_flit_splitter;
    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 2;

    logic             clk = 0;
    logic             rst_n = 0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 0;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data, out1_data, out2_data;
    logic             out0_valid, out1_valid, out2_valid;
    logic             ordy [3];
    logic [CNT_W-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [3][$];
    logic [WIDTH-1:0] last [3];
    int               drops;

    flit_splitter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (ordy[0]),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (ordy[1]),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (ordy[2]),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_ready();
        int d = int'(in_data[WIDTH-1 -: 2]);
        return d == 3 || mq[d].size() < DEPTH;
    endfunction

    // Reference model: per-port queues, pop then push, drops saturate at 2^CNT_W-1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                mq[k].delete();
                last[k] <= '0;
            end
            drops <= 0;
        end else begin
            automatic int  d   = int'(in_data[WIDTH-1 -: 2]);
            automatic bit  acc = in_valid && exp_ready();
            for (int k = 0; k < 3; k++)
                if (mq[k].size() > 0 && ordy[k]) last[k] <= mq[k].pop_front();
            if (acc) begin
                if (d == 3) begin
                    if (drops < (1 << CNT_W) - 1) drops <= drops + 1;
                end else
                    mq[d].push_back(in_data);
            end
        end
    end

    always @(negedge clk) begin
        logic [WIDTH-1:0] dv [3];
        logic             vv [3];
        dv[0] = out0_data; dv[1] = out1_data; dv[2] = out2_data;
        vv[0] = out0_valid; vv[1] = out1_valid; vv[2] = out2_valid;
        check("in_ready", 32'(in_ready), 32'(exp_ready()));
        check("drop_count", 32'(drop_count), 32'(drops));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("out%0d_valid", k), 32'(vv[k]), 32'(mq[k].size() > 0));
            check($sformatf("out%0d_data", k), 32'(dv[k]),
                  32'(mq[k].size() > 0 ? mq[k][0] : last[k]));
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        int n = 0;
        in_valid = 1;
        in_data  = v;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) ordy[k] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 1);
        check("t1_drop", 32'(drop_count), 0);
        check("t1_valid", 32'({out0_valid, out1_valid, out2_valid}), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) ordy[k] = 1;
        send(8'h05);
        check("t2_out0", 32'({out0_valid, out0_data}), 32'h105);
        send(8'h45);
        check("t2_out1", 32'({out1_valid, out1_data}), 32'h145);
        check("t2_out0_gone", 32'(out0_valid), 0);
        send(8'h85);
        check("t2_out2", 32'({out2_valid, out2_data}), 32'h185);
        repeat (2) @(posedge clk); #1;

        ordy[0] = 0;
        send(8'h01);
        send(8'h02);
        in_valid = 1; in_data = 8'h03;
        repeat (2) begin
            @(negedge clk);
            check("t3_blocked", 32'(in_ready), 0);
        end
        @(posedge clk); #1 ordy[0] = 1;
        @(negedge clk);
        check("t3_blocked_pop", 32'(in_ready), 0);
        check("t3_head", 32'(out0_data), 32'h01);
        send(8'h03);
        repeat (4) @(posedge clk); #1;

        send(8'hC0);
        send(8'hC0);
        check("t4_drop2", 32'(drop_count), 2);
        repeat (3) send(8'hC0);
        check("t4_drop_sat", 32'(drop_count), 3);
        check("t4_no_valid", 32'({out0_valid, out1_valid, out2_valid}), 0);

        ordy[1] = 0;
        send(8'h40);
        send(8'h42);
        in_valid = 1; in_data = 8'h41;
        repeat (3) begin
            @(negedge clk);
            check("t5_hol_ready", 32'(in_ready), 0);
            check("t5_out2_idle", 32'(out2_valid), 0);
        end
        @(posedge clk); #1 ordy[1] = 1;
        send(8'h41);
        send(8'h81);
        check("t5_out2", 32'({out2_valid, out2_data}), 32'h181);
        repeat (4) @(posedge clk); #1;

        for (int k = 0; k < 3; k++) ordy[k] = 0;
        send(8'h10);
        send(8'h50);
        send(8'h90);
        @(posedge clk); #3 rst_n = 0;
        #1 check("t6_async_flush", 32'({out0_valid, out1_valid, out2_valid}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        check("t6_after_release", 32'({out0_valid, out1_valid, out2_valid}), 0);
        check("t6_drop_clear", 32'(drop_count), 0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
